// File: rtl/knight_scanner.sv
// Knight-rider style LED scanner. A head LED moves one position per step
// strobe and leaves a trail whose brightness halves each step. Each LED is
// driven by comparing its level against a free-running PWM counter.
module knight_scanner #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        next_pos,
    input  logic                        enable,
    input  logic                        mode,
    output logic [NUM_LEDS-1:0]         leds,
    output logic [$clog2(NUM_LEDS)-1:0] pos,
    output logic                        dir
);

    localparam int POS_W = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0]    LAST_POS  = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]    FIRST_POS = POS_W'(0);
    localparam logic [POS_W-1:0]    POS_ONE   = POS_W'(1);
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [POS_W-1:0]                  pos_q, pos_d;
    logic                              dir_q, dir_d;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0]               leds_q, leds_d;

    // Scan control: enable changes win over steps; a step moves the head,
    // handles the end-of-row bounce or wrap and ages the trail.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        level_d = level_q;
        if (!enable) begin
            state_d = IDLE;
            level_d = '0;
        end else if (state_q == IDLE) begin
            state_d        = dir_q ? MOVE_DOWN : MOVE_UP;
            level_d[pos_q] = MAX_LEVEL;
        end else if (next_pos) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_d[i] = level_q[i] >> 1;
            end
            case (state_q)
                MOVE_UP: begin
                    if (pos_q == LAST_POS) begin
                        if (mode) begin
                            pos_d = FIRST_POS;
                        end else begin
                            pos_d   = LAST_POS - POS_ONE;
                            state_d = MOVE_DOWN;
                        end
                    end else begin
                        pos_d = pos_q + POS_ONE;
                    end
                end
                MOVE_DOWN: begin
                    if (pos_q == FIRST_POS) begin
                        if (mode) begin
                            pos_d = LAST_POS;
                        end else begin
                            pos_d   = POS_ONE;
                            state_d = MOVE_UP;
                        end
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            level_d[pos_d] = MAX_LEVEL;
        end else begin
            state_d = state_q;
        end
    end

    // Direction mirrors the moving state and is remembered while idle.
    always_comb begin
        dir_d = dir_q;
        case (state_d)
            MOVE_UP:   dir_d = 1'b0;
            MOVE_DOWN: dir_d = 1'b1;
            default:   dir_d = dir_q;
        endcase
    end

    // Free-running PWM phase and registered per-LED brightness compare.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_ONE;
        leds_d    = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_d[i] = (level_q[i] > pwm_cnt_q);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            level_q   <= '0;
            pwm_cnt_q <= '0;
            leds_q    <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            level_q   <= level_d;
            pwm_cnt_q <= pwm_cnt_d;
            leds_q    <= leds_d;
        end
    end

    assign leds = leds_q;
    assign pos  = pos_q;
    assign dir  = dir_q;

endmodule

// File: tb/tb_knight_scanner.sv
// Directed, table-driven bench for knight_scanner (default parameters).
module tb_knight_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       next_pos;
    logic       enable;
    logic       mode;
    logic [7:0] leds;
    logic [2:0] pos;
    logic       dir;

    int n_tests = 0;
    int n_fail  = 0;
    int duty [8];

    typedef struct {
        logic mode;
        int   exp_pos;
        int   exp_dir;
    } vec_t;

    vec_t vecs [$];

    knight_scanner #(.NUM_LEDS(8), .PWM_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .next_pos (next_pos),
        .enable   (enable),
        .mode     (mode),
        .leds     (leds),
        .pos      (pos),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One step strobe from the table, then a 20-cycle gap before the next.
    task automatic apply_vec(input int idx);
        mode     = vecs[idx].mode;
        next_pos = 1'b1;
        tick();
        next_pos = 1'b0;
        chk($sformatf("vec%0d_pos", idx), 32'(pos), 32'(vecs[idx].exp_pos));
        chk($sformatf("vec%0d_dir", idx), 32'(dir), 32'(vecs[idx].exp_dir));
        repeat (19) tick();
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < 8; i++) duty[i] = 0;
        repeat (n) begin
            tick();
            for (int i = 0; i < 8; i++) duty[i] += int'(leds[i]);
        end
    endtask

    task automatic chk_duty(input string name, input int e0, input int e1, input int e2,
                            input int e3, input int e4, input int e5, input int e6, input int e7);
        int e [8];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_led%0d", name, i), 32'(duty[i]), 32'(e[i]));
        end
    endtask

    initial begin
        // Segment A: bounce run up to 7, down to 0, bounce back to 1.
        for (int p = 1; p <= 7; p++) vecs.push_back('{1'b0, p, 0});
        for (int p = 6; p >= 0; p--) vecs.push_back('{1'b0, p, 1});
        vecs.push_back('{1'b0, 1, 0});
        // Segment B: up to 7, then wrap forward to 0 and on to 3.
        for (int p = 2; p <= 7; p++) vecs.push_back('{1'b0, p, 0});
        for (int p = 0; p <= 3; p++) vecs.push_back('{1'b1, p, 0});
        // Segment C: wrap up to 7, bounce down, wrap from 0 to 7, stop at 5.
        for (int p = 4; p <= 7; p++) vecs.push_back('{1'b1, p, 0});
        vecs.push_back('{1'b0, 6, 1});
        for (int p = 5; p >= 0; p--) vecs.push_back('{1'b1, p, 1});
        vecs.push_back('{1'b1, 7, 1});
        vecs.push_back('{1'b1, 6, 1});
        vecs.push_back('{1'b1, 5, 1});

        reset = 1'b1; enable = 1'b0; next_pos = 1'b0; mode = 1'b0;
        repeat (3) tick();
        chk("rst_pos",  32'(pos),  32'd0);
        chk("rst_dir",  32'(dir),  32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_pwm",  32'(dut.pwm_cnt_q), 32'd0);

        reset = 1'b0; enable = 1'b1;
        tick();
        for (int i = 0; i <= 14; i++) apply_vec(i);

        // Head at 1 (15), LED0 at 7, LED2 at 1, the rest dark.
        measure(32);
        chk_duty("trail", 14, 30, 2, 0, 0, 0, 0, 0);

        for (int i = 15; i <= 24; i++) apply_vec(i);

        // Enable drop with a coincident step at pos 3.
        enable = 1'b0; next_pos = 1'b1;
        tick();
        next_pos = 1'b0;
        chk("drop_pos1", 32'(pos), 32'd3);
        tick();
        chk("drop_leds", 32'(leds), 32'd0);
        chk("drop_pos2", 32'(pos),  32'd3);
        chk("drop_dir",  32'(dir),  32'd0);
        measure(16);
        chk_duty("idle", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_pos", 32'(pos), 32'd3);

        // Re-enable with a coincident step: the step is ignored.
        enable = 1'b1; next_pos = 1'b1;
        tick();
        next_pos = 1'b0;
        chk("reen_pos", 32'(pos), 32'd3);
        chk("reen_dir", 32'(dir), 32'd0);
        measure(16);
        chk_duty("reen", 0, 0, 0, 15, 0, 0, 0, 0);

        for (int i = 25; i < vecs.size(); i++) apply_vec(i);

        // Reset mid-scan at pos 5 moving down, with step and enable active.
        reset = 1'b1; next_pos = 1'b1;
        tick();
        chk("mid_rst_pos",  32'(pos),  32'd0);
        chk("mid_rst_dir",  32'(dir),  32'd0);
        chk("mid_rst_leds", 32'(leds), 32'd0);
        chk("mid_rst_pwm",  32'(dut.pwm_cnt_q), 32'd0);
        reset = 1'b0; next_pos = 1'b0;
        tick();
        chk("post_rst_pos", 32'(pos), 32'd0);
        chk("post_rst_dir", 32'(dir), 32'd0);
        measure(16);
        chk_duty("post_rst", 15, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/knight_scanner.md
KNIGHT_SCANNER -- requirements
Module: knight_scanner

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning the number of LED outputs; legal range 2..16.
REQ-002 SHALL have parameter PWM_BITS, default 4, meaning the width of each LED brightness level and of the PWM counter.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port next_pos  input  1  single-cycle step strobe, already synchronous to clk; one step per high cycle.
REQ-006 SHALL have port enable  input  1  1 = scanning, 0 = idle with LEDs dark.
REQ-007 SHALL have port mode  input  1  0 = bounce at the ends, 1 = wrap around in the current direction.
REQ-008 SHALL have port leds  output  NUM_LEDS  PWM-modulated LED drive; bit i is LED i.
REQ-009 SHALL have port pos  output  clog2(NUM_LEDS)  registered index of the head LED.
REQ-010 SHALL have port dir  output  1  registered direction; 0 = up (index increasing), 1 = down.

Function
REQ-011 SHALL implement FSM states IDLE, MOVE_UP and MOVE_DOWN; dir SHALL be 1 exactly in MOVE_DOWN, and SHALL keep its last value in IDLE.
REQ-012 IDLE -> MOVE_UP or MOVE_DOWN (per the retained dir) SHALL occur on the first cycle with enable=1; on that edge level[pos] <= 2^PWM_BITS-1.
REQ-013 Any state -> IDLE SHALL occur on any cycle with enable=0; all levels <= 0 on that edge; pos and dir retained.
REQ-014 next_pos SHALL be ignored in IDLE, and when asserted in the same cycle as an enable transition (the enable transition wins).
REQ-015 next_pos=1 in MOVE_UP with pos<NUM_LEDS-1 SHALL give pos <= pos+1 at the next edge.
REQ-016 next_pos=1 in MOVE_DOWN with pos>0 SHALL give pos <= pos-1 at the next edge.
REQ-017 Bounce (mode=0), MOVE_UP at pos=NUM_LEDS-1: pos <= NUM_LEDS-2, state <= MOVE_DOWN.
REQ-018 Bounce (mode=0), MOVE_DOWN at pos=0: pos <= 1, state <= MOVE_UP.
REQ-019 Wrap (mode=1), MOVE_UP at pos=NUM_LEDS-1: pos <= 0, state unchanged; MOVE_DOWN at pos=0: pos <= NUM_LEDS-1, state unchanged.
REQ-020 mode SHALL be sampled only on a step; a change between steps SHALL take effect at the next step, with no direction change of its own.
REQ-021 Trail: on each step, the new head's level SHALL be set to 2^PWM_BITS-1; every other level SHALL be shifted right by 1 (floor), so with PWM_BITS=4 the trail is 15,7,3,1,0.
REQ-022 Without a step, levels SHALL hold.
REQ-023 pwm_cnt (PWM_BITS wide) SHALL increment every cycle in all states, wrapping 2^PWM_BITS-1 -> 0.
REQ-024 leds[i] SHALL be registered as (level[i] > pwm_cnt); it therefore lags level/pwm_cnt by one cycle, and a level-15 LED is dark exactly one cycle in 16.
REQ-025 pos and dir SHALL update one cycle after the next_pos sample (latency 1); leds SHALL reflect a step at latency 2.

Reset
REQ-026 reset=1 SHALL force: state IDLE, pos=0, dir=0, all levels 0, pwm_cnt=0, leds=0.
REQ-027 reset SHALL take priority over enable, next_pos and mode, including mid-scan; the first enable=1 cycle after release SHALL light LED 0 head per REQ-012.

Verification
REQ-028 Reset, enable=1, mode=0, 8 next_pos pulses spaced 20 cycles -> pos 1,2,...,7,6; dir=1 after the 8th pulse.
REQ-029 Continue to pos=0 in MOVE_DOWN, pulse next_pos -> pos=1, dir=0; level[0]=7, level[1]=15.
REQ-030 mode=1 at pos=7 in MOVE_UP, pulse -> pos=0, dir=0; pulse again -> pos=1.
REQ-031 With head steady at 15 and its neighbour at 7, run 32 cycles -> head leds bit high 30 cycles, neighbour high 14 cycles; LEDs at level 0 never high.
REQ-032 Drop enable with next_pos asserted in the same cycle at pos=3 -> leds=0 within 2 cycles; pos holds 3; re-enable -> LED 3 resumes at level 15 in the retained dir.
REQ-033 Assert reset mid-scan at pos=5, dir=1 -> next cycle pos=0, dir=0, leds=0, pwm_cnt=0.
